// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        ic_mem_ask,
  output logic [31:0] ic_mem_addr,
  input  logic        ic_mem_valid,
  input  logic [31:0] ic_mem_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned Lines = 1 << IDX_BITS;
  localparam int unsigned TagW  = 30 - IDX_BITS;

  typedef enum logic [1:0] {StIdle, StMiss, StDrop} state_e;

  state_e              state_q;
  logic [Lines-1:0]    valid_q;
  logic [31:0]         data_arr [Lines];
  logic [TagW-1:0]     tag_arr  [Lines];

  logic [IDX_BITS-1:0] req_idx;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TagW-1:0]     req_tag;
  logic [TagW-1:0]     fill_tag;
  logic                hit;
  logic                accept;
  logic                fill;
  logic                unused_addr_bits;

  assign req_idx  = if_addr[IDX_BITS+1:2];
  assign req_tag  = if_addr[31:IDX_BITS+2];
  // The fill target comes from the latched miss address, not the live fetch PC.
  assign fill_idx = ic_mem_addr[IDX_BITS+1:2];
  assign fill_tag = ic_mem_addr[31:IDX_BITS+2];
  assign unused_addr_bits = ^if_addr[1:0];

  assign hit    = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  // !if_valid keeps a still-held request from being re-accepted during its own response.
  assign accept = if_req && !if_valid && !clear_in;
  assign fill   = ic_mem_valid && (state_q != StIdle);

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      data_arr[fill_idx] <= ic_mem_inst;
      tag_arr[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      if_valid    <= 1'b0;
      if_inst     <= 32'h0;
      ic_mem_ask  <= 1'b0;
      ic_mem_addr <= 32'h0;
`ifdef ICACHE_STATS_EN
      hit_cnt     <= 32'h0;
      miss_cnt    <= 32'h0;
`endif
    end else if (rdy_in) begin
      if_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (hit) begin
              if_inst  <= data_arr[req_idx];
              if_valid <= 1'b1;
`ifdef ICACHE_STATS_EN
              hit_cnt  <= hit_cnt + 32'd1;
`endif
            end else begin
              ic_mem_addr <= {if_addr[31:2], 2'b00};
              ic_mem_ask  <= 1'b1;
              state_q     <= StMiss;
`ifdef ICACHE_STATS_EN
              miss_cnt    <= miss_cnt + 32'd1;
`endif
            end
          end
        end
        StMiss: begin
          if (ic_mem_valid) begin
            valid_q[fill_idx] <= 1'b1;
            ic_mem_ask        <= 1'b0;
            state_q           <= StIdle;
            if (!clear_in) begin
              if_inst  <= ic_mem_inst;
              if_valid <= 1'b1;
            end
          end else if (clear_in) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          // The memory fetch still completes; only the fetcher response is discarded.
          if (ic_mem_valid) begin
            valid_q[fill_idx] <= 1'b1;
            ic_mem_ask        <= 1'b0;
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache plus hand-written flush, freeze and reset sequences.
// Stats checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ic_mem_ask;
  logic [31:0] ic_mem_addr;
  logic        ic_mem_valid;
  logic [31:0] ic_mem_inst;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  icache #(.IDX_BITS(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .ic_mem_ask   (ic_mem_ask),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_valid (ic_mem_valid),
    .ic_mem_inst  (ic_mem_inst)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] inst;
  } vec_t;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One fetch: request held through the response pulse, then one extra cycle to catch duplicates.
  task automatic do_fetch(input logic [31:0] a, input bit miss, input logic [31:0] inst);
    logic [31:0] word;
    word    = {a[31:2], 2'b00};
    if_req  = 1'b1;
    if_addr = a;
    tick();
    if (miss) begin
      check("miss_ask", {31'h0, ic_mem_ask}, 32'h1);
      check("miss_addr", ic_mem_addr, word);
      check("miss_no_valid", {31'h0, if_valid}, 32'h0);
      for (int k = 0; k < 3; k++) begin
        tick();
        check("miss_ask_hold", {31'h0, ic_mem_ask}, 32'h1);
        check("miss_addr_hold", ic_mem_addr, word);
      end
      ic_mem_valid = 1'b1;
      ic_mem_inst  = inst;
      tick();
      ic_mem_valid = 1'b0;
      ic_mem_inst  = 32'h0;
    end
    check("resp_valid", {31'h0, if_valid}, 32'h1);
    check("resp_inst", if_inst, inst);
    check("resp_ask_low", {31'h0, ic_mem_ask}, 32'h0);
    tick();
    check("no_dup_valid", {31'h0, if_valid}, 32'h0);
    check("no_dup_ask", {31'h0, ic_mem_ask}, 32'h0);
    if_req = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{32'h0000_0000, 1'b1, 32'h0000_0513};
    vecs[1]  = '{32'h0000_0000, 1'b0, 32'h0000_0513};
    vecs[2]  = '{32'h0000_0040, 1'b1, 32'h0010_0093};
    vecs[3]  = '{32'h0000_0040, 1'b0, 32'h0010_0093};
    vecs[4]  = '{32'h0000_0000, 1'b1, 32'h0000_0513};
    vecs[5]  = '{32'h0000_0006, 1'b1, 32'h0020_0113};
    vecs[6]  = '{32'h0000_0004, 1'b0, 32'h0020_0113};
    vecs[7]  = '{32'h0000_003C, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{32'hFFFF_FFFC, 1'b1, 32'h1234_5678};
    vecs[9]  = '{32'h0000_003C, 1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{32'h0000_0044, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{32'h0000_0004, 1'b1, 32'h0020_0113};

    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    clear_in     = 1'b0;
    if_req       = 1'b0;
    if_addr      = 32'h0;
    ic_mem_valid = 1'b0;
    ic_mem_inst  = 32'h0;
    #12;
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_ask", {31'h0, ic_mem_ask}, 32'h0);
    check("rst_mem_addr", ic_mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
    rst_in = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_fetch(vecs[i].addr, vecs[i].miss, vecs[i].inst);
`ifdef ICACHE_STATS_EN
      if (i == 1) begin
        check("stat_hit_cnt", hit_cnt, 32'd1);
        check("stat_miss_cnt", miss_cnt, 32'd1);
      end
`endif
    end

    // Asynchronous reset in the middle of a miss.
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    tick();
    check("pre_rst_ask", {31'h0, ic_mem_ask}, 32'h1);
    #2 rst_in = 1'b0;
    #1;
    check("async_rst_ask", {31'h0, ic_mem_ask}, 32'h0);
    check("async_rst_addr", ic_mem_addr, 32'h0);
    if_req = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    do_fetch(32'h0000_0000, 1'b1, 32'h0000_0513);

    // Flush during a miss: the fill completes but yields no response.
    if_req  = 1'b1;
    if_addr = 32'h0000_0004;
    tick();
    check("flush_ask", {31'h0, ic_mem_ask}, 32'h1);
    tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    if_req   = 1'b0;
    tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("drop_ask", {31'h0, ic_mem_ask}, 32'h1);
    check("drop_addr", ic_mem_addr, 32'h0000_0004);
    ic_mem_valid = 1'b1;
    ic_mem_inst  = 32'h0030_0193;
    tick();
    ic_mem_valid = 1'b0;
    check("drop_no_valid", {31'h0, if_valid}, 32'h0);
    check("drop_ask_low", {31'h0, ic_mem_ask}, 32'h0);
    tick();
    check("drop_no_valid2", {31'h0, if_valid}, 32'h0);
    do_fetch(32'h0000_0004, 1'b0, 32'h0030_0193);

    // Freeze with rdy_in low mid-miss.
    if_req  = 1'b1;
    if_addr = 32'h0000_0008;
    tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_ask", {31'h0, ic_mem_ask}, 32'h1);
      check("frz_addr", ic_mem_addr, 32'h0000_0008);
      check("frz_no_valid", {31'h0, if_valid}, 32'h0);
    end
    rdy_in = 1'b1;
    tick();
    ic_mem_valid = 1'b1;
    ic_mem_inst  = 32'h0040_0213;
    tick();
    ic_mem_valid = 1'b0;
    check("frz_resp_valid", {31'h0, if_valid}, 32'h1);
    check("frz_resp_inst", if_inst, 32'h0040_0213);
    check("frz_resp_ask", {31'h0, ic_mem_ask}, 32'h0);
    if_req = 1'b0;
    tick();
    do_fetch(32'h0000_0008, 1'b0, 32'h0040_0213);

    // clear_in on the same edge as ic_mem_valid, then clear_in blocking an IDLE hit.
    if_req  = 1'b1;
    if_addr = 32'h0000_000C;
    tick();
    tick();
    ic_mem_valid = 1'b1;
    ic_mem_inst  = 32'h0050_0293;
    clear_in     = 1'b1;
    tick();
    ic_mem_valid = 1'b0;
    check("clr_fill_no_valid", {31'h0, if_valid}, 32'h0);
    check("clr_fill_ask", {31'h0, ic_mem_ask}, 32'h0);
    tick();
    check("clr_idle_no_valid", {31'h0, if_valid}, 32'h0);
    check("clr_idle_no_ask", {31'h0, ic_mem_ask}, 32'h0);
    clear_in = 1'b0;
    if_req   = 1'b0;
    do_fetch(32'h0000_000C, 1'b0, 32'h0050_0293);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
